// File: rtl/mem_sp_rmw_if.sv
// Byte-enabled single-port memory request bus between the AXI bridge and the RMW controller.
// The master holds req_i and its payload stable until gnt_o. One rvalid_o follows every grant.
interface mem_sp_rmw_if #(
   parameter int DATA_WIDTH     = 64,
   parameter int MEM_ADDR_WIDTH = 10
);
   logic                      req_i;
   logic                      gnt_o;
   logic [MEM_ADDR_WIDTH-1:0] addr_i;
   logic                      we_i;
   logic [DATA_WIDTH/8-1:0]   be_i;
   logic [DATA_WIDTH-1:0]     wdata_i;
   logic [DATA_WIDTH-1:0]     rdata_o;
   logic                      rvalid_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rdata_o, rvalid_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rdata_o, rvalid_o
   );
endinterface

// File: rtl/mem_sp_rmw_ctrl.sv
// Maps byte-enabled requests onto a byte-enable-less single-port SRAM; partial writes become read-modify-write.
// Latency: rvalid_o one cycle after gnt_o; reads/full/null writes 1 per cycle, partial writes 1 per 2 cycles.
// Backpressure: gnt_o stays low during the read half of an RMW; the held request is granted in MERGE.
module mem_sp_rmw_ctrl #(
   parameter int DATA_WIDTH     = 64,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   mem_sp_rmw_if.slave               bus,
   output logic                      CEN_o,
   output logic                      WEN_o,
   output logic [MEM_ADDR_WIDTH-1:0] A_o,
   output logic [DATA_WIDTH-1:0]     D_o,
   input  logic [DATA_WIDTH-1:0]     Q_i,
   output logic [CNT_WIDTH-1:0]      rmw_count_o
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic {IDLE, MERGE} state_t;

   state_t                    state, state_nxt;
   logic [MEM_ADDR_WIDTH-1:0] addr_lat;
   logic [BE_WIDTH-1:0]       be_lat;
   logic [DATA_WIDTH-1:0]     wdata_lat;
   logic [DATA_WIDTH-1:0]     merged;
   logic                      rvalid_q;
   logic                      lat_en;
   logic                      cnt_inc;
   logic                      gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rvalid_q    <= 1'b0;
         rmw_count_o <= '0;
         addr_lat    <= '0;
         be_lat      <= '0;
         wdata_lat   <= '0;
      end else begin
         state    <= state_nxt;
         rvalid_q <= gnt;
         if (lat_en) begin
            addr_lat  <= bus.addr_i;
            be_lat    <= bus.be_i;
            wdata_lat <= bus.wdata_i;
         end
         if (cnt_inc) rmw_count_o <= rmw_count_o + 1'b1;
      end
   end

   // Old bytes come straight from the macro output of the preceding read cycle.
   always_comb begin
      merged = Q_i;
      for (int b = 0; b < BE_WIDTH; b++) begin
         if (be_lat[b]) merged[8*b +: 8] = wdata_lat[8*b +: 8];
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = 1'b0;
      CEN_o     = 1'b1;
      WEN_o     = 1'b1;
      A_o       = '0;
      D_o       = '0;
      lat_en    = 1'b0;
      cnt_inc   = 1'b0;
      // Reset overrides everything so an in-flight merged write is dropped at once.
      if (!rst) begin
         case (state)
            IDLE: begin
               if (bus.req_i) begin
                  if (!bus.we_i) begin
                     gnt   = 1'b1;
                     CEN_o = 1'b0;
                     A_o   = bus.addr_i;
                  end else if (&bus.be_i) begin
                     gnt   = 1'b1;
                     CEN_o = 1'b0;
                     WEN_o = 1'b0;
                     A_o   = bus.addr_i;
                     D_o   = bus.wdata_i;
                  end else if (~|bus.be_i) begin
                     gnt = 1'b1;
                  end else begin
                     CEN_o     = 1'b0;
                     A_o       = bus.addr_i;
                     lat_en    = 1'b1;
                     state_nxt = MERGE;
                  end
               end
            end
            MERGE: begin
               gnt       = 1'b1;
               CEN_o     = 1'b0;
               WEN_o     = 1'b0;
               A_o       = addr_lat;
               D_o       = merged;
               cnt_inc   = ~&rmw_count_o;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = Q_i;
endmodule

// File: tb/tb_mem_sp_rmw_ctrl.sv
// Randomized scoreboard bench for mem_sp_rmw_ctrl against a word-array reference memory and an SRAM macro model.
module tb_mem_sp_rmw_ctrl;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 4;
   localparam int NW = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cen, wen;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [DW-1:0] q;
   logic [CW-1:0] rmw_count;

   always #5 clk = ~clk;

   mem_sp_rmw_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

   mem_sp_rmw_ctrl #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .CEN_o(cen), .WEN_o(wen), .A_o(a), .D_o(d), .Q_i(q), .rmw_count_o(rmw_count)
   );

   typedef struct {
      bit            is_rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            errors = 0;
   int            checks = 0;
   int            exp_cnt = 0;
   logic [DW-1:0] ref_mem [NW];

   function automatic logic [DW-1:0] init_val(int i);
      return 32'h5A00_0000 ^ (i * 32'h0103_0507);
   endfunction

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // SRAM macro: registered read, write-only cycles leave Q unchanged.
   initial begin
      logic [DW-1:0] mem [NW];
      for (int i = 0; i < NW; i++) mem[i] = init_val(i);
      q = '0;
      forever begin
         @(posedge clk);
         if (!cen) begin
            if (!wen) mem[a] <= d;
            else      q <= mem[a];
         end
      end
   end

   // Monitor: every rvalid must follow a grant and match the oldest expectation.
   initial begin
      bit   gnt_prev;
      exp_t e;
      gnt_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (gnt_prev || bus.rvalid_o) chk("rvalid_latency", 32'(bus.rvalid_o), 32'(gnt_prev));
         if (bus.rvalid_o) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got rvalid with no outstanding grant, expected none");
            end else begin
               e = sb.pop_front();
               if (e.is_rd) chk("rdata", bus.rdata_o, e.data);
            end
         end
         gnt_prev = bus.gnt_o;
      end
   end

   task automatic issue(input logic [AW-1:0] addr, input bit we, input logic [3:0] be,
                        input logic [DW-1:0] wdata);
      logic [DW-1:0] old, merged;
      int            waited;
      bit            partial;
      exp_t          e;
      waited  = 0;
      partial = we && be != 4'h0 && be != 4'hF;
      old     = ref_mem[addr];
      for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
      bus.req_i   = 1'b1;
      bus.addr_i  = addr;
      bus.we_i    = we;
      bus.be_i    = be;
      bus.wdata_i = wdata;
      while (1) begin
         @(negedge clk);
         if (waited == 0 && partial) begin
            chk("rmw_rd_gnt", 32'(bus.gnt_o), 0);
            chk("rmw_rd_cen", 32'(cen), 0);
            chk("rmw_rd_wen", 32'(wen), 1);
            chk("rmw_rd_addr", 32'(a), 32'(addr));
         end
         if (bus.gnt_o) break;
         waited++;
         if (waited > 3) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got no grant after %0d cycles, expected %0d", waited, partial ? 1 : 0);
            bus.req_i = 1'b0;
            return;
         end
      end
      chk("gnt_wait", waited, partial ? 1 : 0);
      if (!we) begin
         chk("rd_cen", 32'(cen), 0);
         chk("rd_wen", 32'(wen), 1);
         chk("rd_addr", 32'(a), 32'(addr));
      end else if (be == 4'h0) begin
         chk("null_cen", 32'(cen), 1);
      end else begin
         chk("wr_cen", 32'(cen), 0);
         chk("wr_wen", 32'(wen), 0);
         chk("wr_addr", 32'(a), 32'(addr));
         chk(partial ? "rmw_merge_d" : "full_d", d, merged);
      end
      if (we) ref_mem[addr] = merged;
      e.is_rd = !we;
      e.data  = old;
      sb.push_back(e);
      if (partial && exp_cnt < (1 << CW) - 1) exp_cnt++;
      @(posedge clk);
      #1;
      chk("rmw_count", 32'(rmw_count), 32'(exp_cnt));
   endtask

   task automatic idle(int n);
      bus.req_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] be;
      int         kind;
      for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
      bus.req_i   = 1'b1;
      bus.addr_i  = 4'd3;
      bus.we_i    = 1'b0;
      bus.be_i    = 4'hF;
      bus.wdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rst_cen", 32'(cen), 1);
      chk("rst_wen", 32'(wen), 1);
      chk("rst_gnt", 32'(bus.gnt_o), 0);
      chk("rst_rvalid", 32'(bus.rvalid_o), 0);
      chk("rst_count", 32'(rmw_count), 0);
      chk("rst_a", 32'(a), 0);
      chk("rst_d", d, 0);
      bus.req_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(4'd5, 1'b1, 4'hF, 32'h1122_3344);
      issue(4'd5, 1'b0, 4'h0, 32'h0);
      issue(4'd5, 1'b1, 4'h2, 32'h0000_AB00);
      issue(4'd5, 1'b0, 4'h0, 32'h0);
      chk("t2_ref", ref_mem[5], 32'h1122_AB44);
      issue(4'd5, 1'b1, 4'h0, 32'hFFFF_FFFF);
      issue(4'd5, 1'b0, 4'h0, 32'h0);
      idle(2);

      for (int i = 0; i < 4; i++) issue(AW'(i), 1'b1, 4'hF, 32'hA0 + i);
      for (int i = 0; i < 4; i++) issue(AW'(i), 1'b0, 4'h0, 32'h0);
      idle(1);

      for (int i = 0; i < 17; i++) issue(AW'($urandom_range(0, NW - 1)), 1'b1, 4'h6, $urandom);
      chk("sat_count", 32'(rmw_count), 15);

      issue(4'd7, 1'b1, 4'hF, 32'hFFFF_FFFF);
      bus.req_i   = 1'b1;
      bus.addr_i  = 4'd7;
      bus.we_i    = 1'b1;
      bus.be_i    = 4'h1;
      bus.wdata_i = 32'h0;
      @(negedge clk);
      chk("t5_gnt_low", 32'(bus.gnt_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_cen", 32'(cen), 1);
      chk("t5_wen", 32'(wen), 1);
      chk("t5_gnt", 32'(bus.gnt_o), 0);
      bus.req_i = 1'b0;
      @(negedge clk);
      chk("t5_rvalid", 32'(bus.rvalid_o), 0);
      chk("t5_count", 32'(rmw_count), 0);
      exp_cnt = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(4'd7, 1'b0, 4'h0, 32'h0);
      chk("t5_ref", ref_mem[7], 32'hFFFF_FFFF);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       be = 4'hF;
            1:       be = 4'h0;
            default: be = 4'($urandom_range(1, 14));
         endcase
         issue(AW'($urandom_range(0, NW - 1)), kind != 3 || $urandom_range(0, 1) == 0 ? 1'b1 : 1'b0,
               be, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         else if ($urandom_range(0, 2) == 0) issue(AW'($urandom_range(0, NW - 1)), 1'b0, 4'h0, 32'h0);
      end

      idle(1);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_drain", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_sp_rmw_ctrl.md
Name: mem_sp_rmw_ctrl

Overview:
- Sits directly downstream of the AXI-to-memory interface.
- Converts its byte-enabled, single-port memory request stream into accesses on a single-port SRAM macro. The macro has active-low CEN/WEN and no byte enables.
- Full-word writes and reads go straight through. Partial-byte writes become a two-cycle read-modify-write; the request port is stalled with gnt_o until the merged write is issued.

Parameters:
- DATA_WIDTH, 64, memory word width in bits (multiple of 8).
- MEM_ADDR_WIDTH, 10, word address width.
- CNT_WIDTH, 16, width of the saturating RMW event counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  1  access request; held with all payload stable until gnt_o
- gnt_o  out  1  request accepted this cycle
- addr_i  in  MEM_ADDR_WIDTH  word address
- we_i  in  1  1 = write, 0 = read
- be_i  in  DATA_WIDTH/8  byte enables (writes only)
- wdata_i  in  DATA_WIDTH  write data
- rdata_o  out  DATA_WIDTH  read data, valid when rvalid_o=1 for a read
- rvalid_o  out  1  response pulse, one cycle after every grant
- CEN_o  out  1  macro chip enable, active low
- WEN_o  out  1  macro write enable, active low
- A_o  out  MEM_ADDR_WIDTH  macro address
- D_o  out  DATA_WIDTH  macro write data
- Q_i  in  DATA_WIDTH  macro read data, valid the cycle after a read access
- rmw_count_o  out  CNT_WIDTH  number of completed RMW operations, saturating

Behaviour:
- Reset (async, rst=1): state IDLE, rvalid_o=0, rmw_count_o=0, internal latches cleared.
  - CEN_o=1 and WEN_o=1 are forced while rst=1, regardless of req_i. gnt_o=0, A_o=0, D_o=0.
- Clock domain: single clock, clk.
- FSM states:
  - IDLE
  - MERGE
- IDLE, req_i=0: CEN_o=1, WEN_o=1, gnt_o=0.
- IDLE, read (req_i=1, we_i=0):
  - gnt_o=1 combinationally; CEN_o=0, WEN_o=1, A_o=addr_i. Stay IDLE.
  - Next cycle: rvalid_o=1, rdata_o=Q_i.
- IDLE, full write (be_i all ones):
  - gnt_o=1; CEN_o=0, WEN_o=0, A_o=addr_i, D_o=wdata_i. Stay IDLE. rvalid_o=1 next cycle.
- IDLE, null write (be_i=0):
  - gnt_o=1; no macro access (CEN_o=1). rvalid_o=1 next cycle.
- IDLE, partial write (be_i neither 0 nor all ones):
  - gnt_o=0; CEN_o=0, WEN_o=1, A_o=addr_i.
  - Latch addr_i, be_i, wdata_i; go to MERGE.
- MERGE:
  - Per byte b: D_o[b] = be_lat[b] ? wdata_lat[b] : Q_i[b].
  - CEN_o=0, WEN_o=0, A_o=addr_lat; gnt_o=1 (the held request is accepted now).
  - Increment rmw_count_o unless it is at all ones. Go to IDLE.
  - rvalid_o=1 next cycle.
  - A new request is never granted in MERGE; the next request is evaluated in IDLE on the following cycle.
- Throughput:
  - Reads, full writes and null writes: one per cycle, back-to-back.
  - Partial writes: one per two cycles.
- Latency: rvalid_o exactly one cycle after each gnt_o. Exactly one rvalid_o per grant.
- rdata_o:
  - Combinational copy of Q_i.
  - Meaningful only on rvalid_o following a read. Value is unspecified for write responses.
- Read-after-partial-write to the same address on the next cycle returns the merged data; the macro write completes in MERGE.
- Upstream dropping req_i or changing payload before gnt_o is a protocol violation.
  - Latched values are used in MERGE regardless.
- Reset during MERGE:
  - Merged write is not performed (CEN_o=1 immediately); no gnt_o, no rvalid_o.
  - rmw_count_o is not incremented; it is cleared to 0 by the reset.

Test Plan (DATA_WIDTH=32 unless stated):
1. Full write addr=5, wdata=0x11223344, be=0xF:
   - gnt_o=1 same cycle; CEN_o=0, WEN_o=0, D_o=0x11223344; rvalid_o next cycle.
   - Read addr 5 → rvalid_o with rdata_o=0x11223344.
2. Partial write addr=5, wdata=0x0000AB00, be=0x2:
   - Cycle 0: gnt_o=0, read issued.
   - Cycle 1: gnt_o=1, WEN_o=0, D_o=0x1122AB44.
   - Cycle 2: rvalid_o=1. rmw_count_o=1. Read-back returns 0x1122AB44.
3. Null write be=0x0 to addr 5:
   - gnt_o=1, CEN_o=1 throughout; rvalid_o next cycle.
   - Read addr 5 still returns 0x1122AB44.
4. Back-to-back reads of addr 0,1,2,3 (preloaded 0xA0..0xA3), req held:
   - gnt_o high 4 consecutive cycles; rvalid_o high 4 consecutive cycles.
   - rdata_o = 0xA0, 0xA1, 0xA2, 0xA3 in order.
5. Assert rst in the MERGE cycle of a be=0x1 write to addr 7 (old 0xFFFFFFFF, wdata 0x00):
   - CEN_o=1 immediately; no gnt_o, no rvalid_o; rmw_count_o=0.
   - After reset, read addr 7 → 0xFFFFFFFF.
6. CNT_WIDTH=4, 17 consecutive partial writes:
   - Each takes 2 cycles, gnt_o every second cycle.
   - rmw_count_o reaches 15 and holds 15.
